// File: rtl/icd_cmd_sequencer.sv
// ICD command sequencer: decodes header/address/data bytes from the SPI target,
// runs byte-wide bus cycles on the ICD memory port and returns status or read
// data to the SPI transmit path.
//
// state | meaning
// IDLE  | no command, data bytes ignored (also entered by STATUS header)
// SKIP  | unknown command, data bytes ignored until next header
// ADDR2 | expecting address bits [23:16]
// ADDR1 | expecting address bits [15:8]
// ADDR0 | expecting address bits [7:0]
// DATA  | each data byte launches a write (WRITE) or a read (READ)
module icd_cmd_sequencer #(
    parameter logic [3:0]  VERSION = 4'h1,
    parameter int unsigned BUS_TMO = 255
) (
    input  logic        clk6x,
    input  logic        resetn,
    input  logic [7:0]  rx_byte_i,
    input  logic        rx_hdr_en_i,
    input  logic        rx_db_en_i,
    output logic [7:0]  tx_byte_o,
    output logic        tx_en_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [23:0] bus_addr_o,
    output logic [7:0]  bus_wdata_o,
    input  logic [7:0]  bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        busy_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SKIP  = 3'd1;
    localparam logic [2:0] S_ADDR2 = 3'd2;
    localparam logic [2:0] S_ADDR1 = 3'd3;
    localparam logic [2:0] S_ADDR0 = 3'd4;
    localparam logic [2:0] S_DATA  = 3'd5;

    localparam logic [7:0] TMO_LOAD = 8'(BUS_TMO);

    logic [2:0]  state;
    logic        cmd_rd;
    logic [23:0] addr;
    logic        req;
    logic        we;
    logic [23:0] baddr;
    logic [7:0]  wdata;
    logic [7:0]  tmo_cnt;
    logic        disc;          // header seen since launch: drop the result
    logic        launch_pend;   // first read of a READ waits for an old cycle
    logic        status_pend;
    logic        rd_pend;
    logic [7:0]  tx_q;
    logic        ovr;
    logic        tmo;

    logic        hdr;
    logic        db;
    logic        tmo_hit;
    logic        bus_done;
    logic        blocked;
    logic        launch_a0;
    logic        launch_db;
    logic        launch_lp;
    logic        launch;
    logic        launch_we;
    logic [23:0] launch_addr;
    logic        ovr_set;

    // Strobe qualification, launch decisions and flag-set conditions.
    always_comb begin
        hdr         = rx_hdr_en_i;
        db          = rx_db_en_i & ~rx_hdr_en_i;
        tmo_hit     = req & ~bus_ack_i & (tmo_cnt == 8'd1);
        bus_done    = req & (bus_ack_i | tmo_hit);
        blocked     = req | launch_pend;
        launch_a0   = db & (state == S_ADDR0) & cmd_rd & ~req;
        launch_db   = db & (state == S_DATA) & ~blocked;
        launch_lp   = launch_pend & ~req & ~hdr;
        launch      = launch_a0 | launch_db | launch_lp;
        launch_we   = launch_db & ~cmd_rd;
        launch_addr = launch_a0 ? {addr[23:8], rx_byte_i} : addr;
        // A status strobe colliding with read data loses the read data.
        ovr_set     = (db & (state == S_DATA) & blocked) | (status_pend & rd_pend);
    end

    assign busy_o      = ((state != S_IDLE) && (state != S_SKIP)) | req | launch_pend;
    assign tx_en_o     = status_pend | rd_pend;
    assign tx_byte_o   = status_pend ? {ovr, tmo, busy_o, 1'b0, VERSION} : tx_q;
    assign bus_req_o   = req;
    assign bus_we_o    = we;
    assign bus_addr_o  = baddr;
    assign bus_wdata_o = wdata;

    // Command decode FSM, address pointer and bus handshake.
    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            cmd_rd      <= 1'b0;
            addr        <= '0;
            req         <= 1'b0;
            we          <= 1'b0;
            baddr       <= '0;
            wdata       <= '0;
            tmo_cnt     <= '0;
            disc        <= 1'b0;
            launch_pend <= 1'b0;
            status_pend <= 1'b0;
            rd_pend     <= 1'b0;
            tx_q        <= '0;
        end else begin
            status_pend <= hdr;
            rd_pend     <= 1'b0;

            if (launch_lp) begin
                launch_pend <= 1'b0;
            end

            if (hdr) begin
                cmd_rd      <= (rx_byte_i[7:4] == 4'h2);
                launch_pend <= 1'b0;
                case (rx_byte_i[7:4])
                    4'h0:       state <= S_IDLE;
                    4'h1, 4'h2: state <= S_ADDR2;
                    default:    state <= S_SKIP;
                endcase
            end else if (db) begin
                case (state)
                    S_ADDR2: begin
                        addr[23:16] <= rx_byte_i;
                        state       <= S_ADDR1;
                    end
                    S_ADDR1: begin
                        addr[15:8] <= rx_byte_i;
                        state      <= S_ADDR0;
                    end
                    S_ADDR0: begin
                        addr[7:0] <= rx_byte_i;
                        state     <= S_DATA;
                        if (cmd_rd && req) begin
                            launch_pend <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (req) begin
                if (bus_done) begin
                    req  <= 1'b0;
                    disc <= 1'b0;
                    if (!disc) begin
                        addr <= baddr + 24'd1;
                        if (!we) begin
                            tx_q    <= bus_ack_i ? bus_rdata_i : 8'hFF;
                            rd_pend <= 1'b1;
                        end
                    end
                end else begin
                    tmo_cnt <= tmo_cnt - 8'd1;
                    if (hdr) begin
                        disc <= 1'b1;
                    end
                end
            end else if (launch) begin
                req     <= 1'b1;
                we      <= launch_we;
                baddr   <= launch_addr;
                wdata   <= launch_we ? rx_byte_i : 8'h00;
                tmo_cnt <= TMO_LOAD;
            end
        end
    end

    // Sticky error flags, cleared by the status strobe unless set again at once.
    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            ovr <= 1'b0;
            tmo <= 1'b0;
        end else begin
            ovr <= (ovr & ~status_pend) | ovr_set;
            tmo <= (tmo & ~status_pend) | tmo_hit;
        end
    end

endmodule

// File: tb/tb_icd_cmd_sequencer.sv
// Directed bench for icd_cmd_sequencer with expected-result queues for the
// transmit strobes and bus cycle launches.
module tb_icd_cmd_sequencer;

    logic        clk6x = 1'b0;
    logic        resetn;
    logic [7:0]  rx_byte_i;
    logic        rx_hdr_en_i;
    logic        rx_db_en_i;
    logic [7:0]  tx_byte_o;
    logic        tx_en_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [23:0] bus_addr_o;
    logic [7:0]  bus_wdata_o;
    logic [7:0]  bus_rdata_i;
    logic        bus_ack_i;
    logic        busy_o;

    icd_cmd_sequencer dut (
        .clk6x       (clk6x),
        .resetn      (resetn),
        .rx_byte_i   (rx_byte_i),
        .rx_hdr_en_i (rx_hdr_en_i),
        .rx_db_en_i  (rx_db_en_i),
        .tx_byte_o   (tx_byte_o),
        .tx_en_o     (tx_en_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i),
        .busy_o      (busy_o)
    );

    always #5 clk6x = ~clk6x;

    // Output monitor: logs tx strobes, bus launches and bus stability breaks.
    logic [7:0]  tx_log  [64];
    logic [32:0] bus_log [64];
    logic [5:0]  tx_n     = '0;
    logic [5:0]  bus_n    = '0;
    logic [7:0]  stab_err = '0;
    logic        req_q    = 1'b0;
    logic [32:0] bus_prev = '0;

    always @(negedge clk6x) begin
        if (tx_en_o) begin
            tx_log[tx_n] <= tx_byte_o;
            tx_n         <= tx_n + 6'd1;
        end
        if (bus_req_o && !req_q) begin
            bus_log[bus_n] <= {bus_we_o, bus_addr_o, bus_wdata_o};
            bus_n          <= bus_n + 6'd1;
        end
        if (bus_req_o && req_q && ({bus_we_o, bus_addr_o, bus_wdata_o} != bus_prev)) begin
            stab_err <= stab_err + 8'd1;
        end
        req_q    <= bus_req_o;
        bus_prev <= {bus_we_o, bus_addr_o, bus_wdata_o};
    end

    int          total = 0;
    int          bad   = 0;
    logic [5:0]  rd_tx  = '0;
    logic [5:0]  rd_bus = '0;
    logic [7:0]  exp_tx  [$];
    logic [32:0] exp_bus [$];

    function automatic logic [7:0] stat(input logic o, input logic t, input logic b);
        return {o, t, b, 1'b0, 4'h1};
    endfunction

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic strobe(input logic h, input logic [7:0] b);
        rx_byte_i   = b;
        rx_hdr_en_i = h;
        rx_db_en_i  = ~h;
        @(posedge clk6x); #1;
        rx_hdr_en_i = 1'b0;
        rx_db_en_i  = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk6x); #1;
        end
    endtask

    task automatic ack(input logic [7:0] d);
        bus_rdata_i = d;
        bus_ack_i   = 1'b1;
        @(posedge clk6x); #1;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 8'h00;
    endtask

    task automatic wait_tx(input string tag);
        logic [7:0] e;
        int n = 0;
        while (tx_n == rd_tx && n < 400) begin
            @(posedge clk6x); #1;
            n++;
        end
        chk({tag, "_arrive"}, {47'd0, tx_n != rd_tx}, 48'd1);
        if (tx_n != rd_tx && exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            chk(tag, {40'd0, tx_log[rd_tx]}, {40'd0, e});
            rd_tx = rd_tx + 6'd1;
        end
    endtask

    task automatic wait_bus(input string tag);
        logic [32:0] e;
        int n = 0;
        while (bus_n == rd_bus && n < 400) begin
            @(posedge clk6x); #1;
            n++;
        end
        chk({tag, "_arrive"}, {47'd0, bus_n != rd_bus}, 48'd1);
        if (bus_n != rd_bus && exp_bus.size() > 0) begin
            e = exp_bus.pop_front();
            chk(tag, {15'd0, bus_log[rd_bus]}, {15'd0, e});
            rd_bus = rd_bus + 6'd1;
        end
    endtask

    initial begin
        int n;
        resetn      = 1'b0;
        rx_byte_i   = 8'h00;
        rx_hdr_en_i = 1'b0;
        rx_db_en_i  = 1'b0;
        bus_rdata_i = 8'h00;
        bus_ack_i   = 1'b0;
        repeat (3) @(posedge clk6x);
        #1;
        chk("reset_outputs", {4'd0, tx_en_o, tx_byte_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, busy_o}, 48'd0);
        resetn = 1'b1;
        cyc(2);

        // WRITE: AA@001234, BB@001235
        exp_tx.push_back(stat(0, 0, 1));
        strobe(1, 8'h10);
        wait_tx("wr_hdr_status");
        strobe(0, 8'h00); strobe(0, 8'h12); strobe(0, 8'h34);
        exp_bus.push_back({1'b1, 24'h001234, 8'hAA});
        strobe(0, 8'hAA);
        chk("wr_req_latency", {47'd0, bus_req_o}, 48'd1);
        wait_bus("wr_cycle0");
        ack(8'h00);
        exp_bus.push_back({1'b1, 24'h001235, 8'hBB});
        strobe(0, 8'hBB);
        wait_bus("wr_cycle1");
        ack(8'h00);
        exp_tx.push_back(stat(0, 0, 0));
        strobe(1, 8'h00);
        wait_tx("wr_status_after");

        // READ with address wrap
        exp_tx.push_back(stat(0, 0, 1));
        strobe(1, 8'h20);
        wait_tx("rd_hdr_status");
        strobe(0, 8'hFF); strobe(0, 8'hFF);
        exp_bus.push_back({1'b0, 24'hFFFFFF, 8'h00});
        strobe(0, 8'hFF);
        chk("rd_req_latency", {47'd0, bus_req_o}, 48'd1);
        wait_bus("rd_cycle0");
        exp_tx.push_back(8'h5A);
        ack(8'h5A);
        chk("ack_tx_latency", {47'd0, tx_en_o}, 48'd1);
        wait_tx("rd_data0");
        exp_bus.push_back({1'b0, 24'h000000, 8'h00});
        strobe(0, 8'h00);
        wait_bus("rd_cycle_wrap");
        exp_tx.push_back(8'hC3);
        ack(8'hC3);
        wait_tx("rd_data1");
        exp_bus.push_back({1'b0, 24'h000001, 8'h00});
        strobe(0, 8'h00);
        wait_bus("rd_cycle2");
        exp_tx.push_back(8'h77);
        ack(8'h77);
        wait_tx("rd_data2");

        // Timeout on a read
        exp_tx.push_back(stat(0, 0, 1));
        strobe(1, 8'h20);
        wait_tx("tmo_hdr_status");
        strobe(0, 8'h00); strobe(0, 8'h00);
        exp_bus.push_back({1'b0, 24'h000040, 8'h00});
        strobe(0, 8'h40);
        n = 0;
        while (bus_req_o && n < 300) begin
            n++;
            @(posedge clk6x); #1;
        end
        chk("tmo_req_cycles", 48'(n), 48'd255);
        wait_bus("tmo_cycle");
        exp_tx.push_back(8'hFF);
        wait_tx("tmo_tx_ff");
        exp_bus.push_back({1'b0, 24'h000041, 8'h00});
        strobe(0, 8'h00);
        wait_bus("tmo_addr_incr");
        exp_tx.push_back(8'h11);
        ack(8'h11);
        wait_tx("tmo_next_data");
        exp_tx.push_back(stat(0, 1, 0));
        strobe(1, 8'h00);
        wait_tx("tmo_status_set");
        exp_tx.push_back(stat(0, 0, 0));
        strobe(1, 8'h00);
        wait_tx("tmo_status_clr");

        // Overrun on write
        exp_tx.push_back(stat(0, 0, 1));
        strobe(1, 8'h10);
        wait_tx("ovr_hdr_status");
        strobe(0, 8'h00); strobe(0, 8'h00);
        strobe(0, 8'h80);
        exp_bus.push_back({1'b1, 24'h000080, 8'h01});
        strobe(0, 8'h01);
        strobe(0, 8'h02);
        wait_bus("ovr_cycle");
        ack(8'h00);
        cyc(3);
        chk("ovr_single_cycle", {42'd0, bus_n}, {42'd0, rd_bus});
        exp_tx.push_back(stat(1, 0, 0));
        strobe(1, 8'h00);
        wait_tx("ovr_status");

        // Unknown command
        exp_tx.push_back(stat(0, 0, 0));
        strobe(1, 8'h70);
        wait_tx("skip_hdr_status");
        strobe(0, 8'h01); strobe(0, 8'h02); strobe(0, 8'h03);
        cyc(3);
        chk("skip_no_bus", {42'd0, bus_n}, {42'd0, rd_bus});
        chk("skip_not_busy", {47'd0, busy_o}, 48'd0);

        // New header while a read is pending
        exp_tx.push_back(stat(0, 0, 1));
        strobe(1, 8'h20);
        wait_tx("rehdr_rd_status");
        strobe(0, 8'h00); strobe(0, 8'h01);
        exp_bus.push_back({1'b0, 24'h000100, 8'h00});
        strobe(0, 8'h00);
        wait_bus("rehdr_cycle");
        exp_tx.push_back(stat(0, 0, 1));
        strobe(1, 8'h00);
        wait_tx("rehdr_status");
        ack(8'h99);
        cyc(3);
        chk("rehdr_data_dropped", {42'd0, tx_n}, {42'd0, rd_tx});
        chk("rehdr_idle", {47'd0, busy_o}, 48'd0);

        // Asynchronous reset in the middle of a bus cycle
        exp_tx.push_back(stat(0, 0, 1));
        strobe(1, 8'h10);
        wait_tx("rst_hdr_status");
        strobe(0, 8'h00); strobe(0, 8'h00); strobe(0, 8'h00);
        exp_bus.push_back({1'b1, 24'h000000, 8'h05});
        strobe(0, 8'h05);
        wait_bus("rst_cycle");
        #3;
        resetn = 1'b0;
        #1;
        chk("async_reset_outputs", {4'd0, tx_en_o, tx_byte_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, busy_o}, 48'd0);
        #2;
        resetn = 1'b1;
        cyc(2);
        chk("post_reset_idle", {47'd0, busy_o}, 48'd0);
        exp_tx.push_back(stat(0, 0, 0));
        strobe(1, 8'h00);
        wait_tx("post_reset_status");

        chk("bus_stable_while_req", {40'd0, stab_err}, 48'd0);
        chk("no_extra_bus", {42'd0, bus_n}, {42'd0, rd_bus});
        chk("no_extra_tx", {42'd0, tx_n}, {42'd0, rd_tx});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
